// File: rtl/cosmac_bus_master_pkg.sv
// Shared constants for the COSMAC-style bus master: phase windows of the
// eight-phase bus cycle, counter widths and the FSM state type.
package cosmac_bus_master_pkg;

    localparam int PHASE_CLKS_DEF = 2;
    localparam int SUB_W          = 4;   // holds PHASE_CLKS-1 for PHASE_CLKS up to 16

    localparam logic [2:0] PH_TPA        = 3'd0;
    localparam logic [2:0] PH_MA_HI_LAST = 3'd1;
    localparam logic [2:0] PH_MRD_FIRST  = 3'd2;
    localparam logic [2:0] PH_OE_FIRST   = 3'd3;
    localparam logic [2:0] PH_MWR_FIRST  = 3'd4;
    localparam logic [2:0] PH_WAIT       = 3'd5;
    localparam logic [2:0] PH_TPB        = 3'd6;
    localparam logic [2:0] PH_OE_LAST    = 3'd6;
    localparam logic [2:0] PH_MWR_LAST   = 3'd6;
    localparam logic [2:0] PH_LAST       = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CYCLE = 1'b1
    } state_t;

    function automatic logic in_phases(input logic [2:0] ph,
                                       input logic [2:0] lo,
                                       input logic [2:0] hi);
        return (ph >= lo) && (ph <= hi);
    endfunction

endpackage

// File: rtl/cosmac_bus_master_if.sv
// Host handshake plus COSMAC memory bus, bundled so the master and the
// memory/host side each see one port.
interface cosmac_bus_master_if;

    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ready;
    logic        done;
    logic [7:0]  rdata;
    logic        tpa;
    logic        tpb;
    logic [7:0]  ma;
    logic        nmrd;
    logic        nmwr;
    logic [7:0]  db_out;
    logic        db_oe;
    logic [7:0]  db_in;
    logic        nwait;

    modport master (
        input  req, we, addr, wdata, db_in, nwait,
        output ready, done, rdata, tpa, tpb, ma, nmrd, nmwr, db_out, db_oe
    );

    modport slave (
        output req, we, addr, wdata, db_in, nwait,
        input  ready, done, rdata, tpa, tpb, ma, nmrd, nmwr, db_out, db_oe
    );

endinterface

// File: rtl/cosmac_bus_master_phase_timer.sv
// Sub-phase / phase counters for one bus cycle. Exposes both current and
// next-clock values so the master can register its outputs one clock ahead.
module cosmac_phase_timer
    import cosmac_bus_master_pkg::*;
#(
    parameter int PHASE_CLKS = PHASE_CLKS_DEF
) (
    input  logic       clk_16mhz,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_stall,
    output logic [2:0] o_phase,
    output logic       o_last,
    output logic [2:0] o_phase_nxt,
    output logic       o_last_nxt
);

    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(PHASE_CLKS - 1);

    logic [SUB_W-1:0] r_sub;
    logic [2:0]       r_phase;
    logic [SUB_W-1:0] w_sub_nxt;
    logic [2:0]       w_phase_nxt;
    logic             w_last;

    assign w_last = (r_sub == SUB_MAX);

    // A stall on the last clock restarts the same phase from sub-phase 0.
    always_comb begin
        w_sub_nxt   = r_sub;
        w_phase_nxt = r_phase;
        if (i_en) begin
            if (w_last) begin
                w_sub_nxt = '0;
                if (!i_stall)
                    w_phase_nxt = r_phase + 3'd1;
            end else begin
                w_sub_nxt = r_sub + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            r_sub   <= '0;
            r_phase <= '0;
        end else begin
            r_sub   <= w_sub_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    assign o_phase     = r_phase;
    assign o_last      = w_last;
    assign o_phase_nxt = w_phase_nxt;
    assign o_last_nxt  = (w_sub_nxt == SUB_MAX);

endmodule

// File: rtl/cosmac_bus_master.sv
// Host-to-COSMAC bus master: runs one eight-phase memory cycle per accepted
// request, with nwait stretching phase 5. Every output is a flop.
module cosmac_bus_master
    import cosmac_bus_master_pkg::*;
#(
    parameter int PHASE_CLKS = PHASE_CLKS_DEF
) (
    input  logic                clk_16mhz,
    input  logic                rst,
    cosmac_bus_master_if.master bus
);

    state_t      r_state;
    logic        r_we;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;

    logic        r_ready;
    logic        r_done;
    logic [7:0]  r_rdata;
    logic        r_tpa;
    logic        r_tpb;
    logic [7:0]  r_ma;
    logic        r_nmrd;
    logic        r_nmwr;
    logic [7:0]  r_db_out;
    logic        r_db_oe;

    logic [2:0]  w_phase;
    logic        w_last;
    logic [2:0]  w_phase_nxt;
    logic        w_last_nxt;

    logic        w_cyc;
    logic        w_end;
    logic        w_stall;
    logic        w_accept;
    state_t      w_state_nxt;
    logic        w_busy_nxt;
    logic        w_we_nxt;
    logic [15:0] w_addr_nxt;
    logic [7:0]  w_wdata_nxt;
    logic        w_oe_nxt;

    cosmac_phase_timer #(.PHASE_CLKS(PHASE_CLKS)) u_timer (
        .clk_16mhz   (clk_16mhz),
        .rst         (rst),
        .i_en        (w_cyc),
        .i_stall     (w_stall),
        .o_phase     (w_phase),
        .o_last      (w_last),
        .o_phase_nxt (w_phase_nxt),
        .o_last_nxt  (w_last_nxt)
    );

    assign w_cyc    = (r_state == ST_CYCLE);
    assign w_end    = w_cyc && w_last && (w_phase == PH_LAST);
    assign w_stall  = w_cyc && w_last && (w_phase == PH_WAIT) && !bus.nwait;
    assign w_accept = bus.req && r_ready;

    // Counters are back at 0/0 whenever the FSM leaves CYCLE, so an accept
    // (from IDLE or back-to-back at cycle end) always starts at phase 0.
    always_comb begin
        w_state_nxt = ST_CYCLE;
        if (!w_accept && (w_end || !w_cyc))
            w_state_nxt = ST_IDLE;
    end

    assign w_busy_nxt  = (w_state_nxt == ST_CYCLE);
    assign w_we_nxt    = w_accept ? bus.we    : r_we;
    assign w_addr_nxt  = w_accept ? bus.addr  : r_addr;
    assign w_wdata_nxt = w_accept ? bus.wdata : r_wdata;
    assign w_oe_nxt    = w_busy_nxt && w_we_nxt &&
                         in_phases(w_phase_nxt, PH_OE_FIRST, PH_OE_LAST);

    // Outputs are decoded from next-clock state so the pins change on the
    // same edge as the phase they describe.
    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_we     <= 1'b0;
            r_addr   <= 16'h0000;
            r_wdata  <= 8'h00;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_rdata  <= 8'h00;
            r_tpa    <= 1'b0;
            r_tpb    <= 1'b0;
            r_ma     <= 8'h00;
            r_nmrd   <= 1'b1;
            r_nmwr   <= 1'b1;
            r_db_out <= 8'h00;
            r_db_oe  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_ready <= !w_busy_nxt || ((w_phase_nxt == PH_LAST) && w_last_nxt);
            r_done  <= w_end;
            if (w_end && !r_we)
                r_rdata <= bus.db_in;
            r_tpa   <= w_busy_nxt && (w_phase_nxt == PH_TPA);
            r_tpb   <= w_busy_nxt && (w_phase_nxt == PH_TPB);
            if (!w_busy_nxt)
                r_ma <= 8'h00;
            else if (w_phase_nxt <= PH_MA_HI_LAST)
                r_ma <= w_addr_nxt[15:8];
            else
                r_ma <= w_addr_nxt[7:0];
            r_nmrd   <= !(w_busy_nxt && !w_we_nxt && (w_phase_nxt >= PH_MRD_FIRST));
            r_nmwr   <= !(w_busy_nxt && w_we_nxt &&
                          in_phases(w_phase_nxt, PH_MWR_FIRST, PH_MWR_LAST));
            r_db_oe  <= w_oe_nxt;
            r_db_out <= w_oe_nxt ? w_wdata_nxt : 8'h00;
        end
    end

    assign bus.ready  = r_ready;
    assign bus.done   = r_done;
    assign bus.rdata  = r_rdata;
    assign bus.tpa    = r_tpa;
    assign bus.tpb    = r_tpb;
    assign bus.ma     = r_ma;
    assign bus.nmrd   = r_nmrd;
    assign bus.nmwr   = r_nmwr;
    assign bus.db_out = r_db_out;
    assign bus.db_oe  = r_db_oe;

endmodule

// File: tb/tb_cosmac_bus_master.sv
// Bench for cosmac_bus_master: a PHASE_CLKS=2 and a PHASE_CLKS=1 instance
// share stimulus; a clock-count model checks both every cycle.
module tb_cosmac_bus_master;

    logic        clk = 1'b0;
    logic        rst, req, we, nwait;
    logic [15:0] addr;
    logic [7:0]  wdata, db_in;
    int          n_checks = 0;
    int          n_errs   = 0;

    always #5 clk = ~clk;

    cosmac_bus_master_if bus0();
    cosmac_bus_master_if bus1();

    assign bus0.req = req;   assign bus1.req = req;
    assign bus0.we = we;     assign bus1.we = we;
    assign bus0.addr = addr; assign bus1.addr = addr;
    assign bus0.wdata = wdata; assign bus1.wdata = wdata;
    assign bus0.db_in = db_in; assign bus1.db_in = db_in;
    assign bus0.nwait = nwait; assign bus1.nwait = nwait;

    cosmac_bus_master #(.PHASE_CLKS(2)) u_dut0 (.clk_16mhz(clk), .rst(rst), .bus(bus0.master));
    cosmac_bus_master #(.PHASE_CLKS(1)) u_dut1 (.clk_16mhz(clk), .rst(rst), .bus(bus1.master));

    // Model: a cycle is a count of clocks since accept; phase 5 is stretched
    // by m_ext whole phases, one per low nwait sample.
    int          pcs[2] = '{2, 1};
    bit          m_busy[2];
    int          m_c[2];
    int          m_ext[2];
    bit          m_we[2];
    logic [15:0] m_addr[2];
    logic [7:0]  m_wd[2];
    logic [7:0]  m_rd[2];
    bit          m_done[2];

    function automatic int phase_of(input int i);
        int q;
        q = (m_c[i] - 1) / pcs[i];
        if (q < 5) return q;
        if (q <= 5 + m_ext[i]) return 5;
        return q - m_ext[i];
    endfunction

    function automatic bit last_of(input int i);
        return ((m_c[i] - 1) % pcs[i]) == pcs[i] - 1;
    endfunction

    task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s dut%0d t=%0t got %h expected %h", nm, i, $time, act, exp);
        end
    endtask

    task automatic cmp_inst(input int i, input logic rdy, input logic dn, input logic ta,
                            input logic tb_, input logic [7:0] ma, input logic rd,
                            input logic wr, input logic oe, input logic [7:0] dbo,
                            input logic [7:0] rdat);
        int p;
        bit b, l, e_oe;
        p = phase_of(i);
        b = m_busy[i];
        l = last_of(i);
        e_oe = b && m_we[i] && p >= 3 && p <= 6;
        chk("ready", i, 16'(rdy), 16'(!b || (p == 7 && l)));
        chk("done",  i, 16'(dn),  16'(m_done[i]));
        chk("tpa",   i, 16'(ta),  16'(b && p == 0));
        chk("tpb",   i, 16'(tb_), 16'(b && p == 6));
        chk("ma",    i, 16'(ma),  16'(!b ? 8'h00 : (p < 2 ? m_addr[i][15:8] : m_addr[i][7:0])));
        chk("nmrd",  i, 16'(rd),  16'(!(b && !m_we[i] && p >= 2)));
        chk("nmwr",  i, 16'(wr),  16'(!(b && m_we[i] && p >= 4 && p <= 6)));
        chk("db_oe", i, 16'(oe),  16'(e_oe));
        if (e_oe) chk("db_out", i, 16'(dbo), 16'(m_wd[i]));
        chk("rdata", i, 16'(rdat), 16'(m_rd[i]));
    endtask

    task automatic adv_inst(input int i);
        int p;
        bit b, l, fin, e_ready;
        p = phase_of(i);
        b = m_busy[i];
        l = last_of(i);
        e_ready = !b || (p == 7 && l);
        if (rst) begin
            m_busy[i] = 0; m_c[i] = 0; m_ext[i] = 0; m_done[i] = 0; m_rd[i] = 8'h00;
            return;
        end
        fin = b && p == 7 && l;
        if (fin && !m_we[i]) m_rd[i] = db_in;
        if (b && p == 5 && l && !nwait) m_ext[i]++;
        if (fin || !b) begin
            m_ext[i] = 0;
            if (req && e_ready) begin
                m_busy[i] = 1; m_c[i] = 1;
                m_we[i] = we; m_addr[i] = addr; m_wd[i] = wdata;
            end else begin
                m_busy[i] = 0; m_c[i] = 0;
            end
        end else begin
            m_c[i]++;
        end
        m_done[i] = fin;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_c[i] = 0; m_ext[i] = 0; m_we[i] = 0;
            m_addr[i] = 16'h0; m_wd[i] = 8'h0; m_rd[i] = 8'h0; m_done[i] = 0;
        end
        forever begin
            @(negedge clk);
            cmp_inst(0, bus0.ready, bus0.done, bus0.tpa, bus0.tpb, bus0.ma, bus0.nmrd,
                     bus0.nmwr, bus0.db_oe, bus0.db_out, bus0.rdata);
            cmp_inst(1, bus1.ready, bus1.done, bus1.tpa, bus1.tpb, bus1.ma, bus1.nmrd,
                     bus1.nmwr, bus1.db_oe, bus1.db_out, bus1.rdata);
            adv_inst(0);
            adv_inst(1);
        end
    end

    initial begin
        rst = 1; req = 0; we = 0; addr = 16'h0; wdata = 8'h0; db_in = 8'h0; nwait = 1;
        @(negedge clk);
        chk("rst_ready", 0, 16'(bus0.ready), 16'd1);
        chk("rst_nmrd",  0, 16'(bus0.nmrd),  16'd1);
        chk("rst_nmwr",  0, 16'(bus0.nmwr),  16'd1);
        chk("rst_ma",    0, 16'(bus0.ma),    16'h00);
        chk("rst_rdata", 0, 16'(bus0.rdata), 16'h00);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;

        // Read F003, single request; PHASE_CLKS=1 instance runs alongside
        we = 0; addr = 16'hF003; db_in = 8'hA5; req = 1;
        @(posedge clk); #1 req = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("A_tpa",  0, 16'(bus0.tpa),  16'(k == 1 || k == 2));
            chk("A_tpb",  0, 16'(bus0.tpb),  16'(k == 13 || k == 14));
            chk("A_ma",   0, 16'(bus0.ma),   16'(k <= 4 ? 8'hF0 : (k <= 16 ? 8'h03 : 8'h00)));
            chk("A_done", 0, 16'(bus0.done), 16'(k == 17));
            if (k == 17) chk("A_rdata", 0, 16'(bus0.rdata), 16'hA5);
            chk("A1_done", 1, 16'(bus1.done), 16'(k == 9));
            chk("A1_tpb",  1, 16'(bus1.tpb),  16'(k == 7));
            chk("A1_nmrd", 1, 16'(bus1.nmrd), 16'(!(k >= 3 && k <= 8)));
            @(posedge clk); #1;
        end

        // Write 0007 <- CC
        we = 1; addr = 16'h0007; wdata = 8'hCC; db_in = 8'h5A; req = 1;
        @(posedge clk); #1 req = 0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            chk("B_oe",   0, 16'(bus0.db_oe), 16'(k >= 7 && k <= 14));
            chk("B_nmwr", 0, 16'(bus0.nmwr),  16'(!(k >= 9 && k <= 14)));
            chk("B_nmrd", 0, 16'(bus0.nmrd),  16'd1);
            chk("B_done", 0, 16'(bus0.done),  16'(k == 17));
            if (k == 17) chk("B_rdata", 0, 16'(bus0.rdata), 16'hA5);
            @(posedge clk); #1;
        end

        // Read with nwait low for three phase-5 samples
        we = 0; addr = 16'h1234; db_in = 8'h3C; req = 1;
        @(posedge clk); #1 req = 0;
        for (int k = 1; k <= 25; k++) begin
            nwait = (k >= 11 && k <= 16) ? 1'b0 : 1'b1;
            @(negedge clk);
            chk("C_tpb",  0, 16'(bus0.tpb),  16'(k == 19 || k == 20));
            chk("C_done", 0, 16'(bus0.done), 16'(k == 23));
            if (k == 23) chk("C_rdata", 0, 16'(bus0.rdata), 16'h3C);
            @(posedge clk); #1;
        end
        nwait = 1;

        // req held: read then write back-to-back
        we = 0; addr = 16'hAA55; db_in = 8'h77; req = 1;
        @(posedge clk); #1;
        we = 1; addr = 16'h0102; wdata = 8'h3C;
        for (int k = 1; k <= 36; k++) begin
            if (k == 17) req = 0;
            @(negedge clk);
            chk("D_ready", 0, 16'(bus0.ready), 16'(k == 16 || k >= 32));
            chk("D_tpa",   0, 16'(bus0.tpa),   16'(k == 1 || k == 2 || k == 17 || k == 18));
            chk("D_done",  0, 16'(bus0.done),  16'(k == 17 || k == 33));
            if (k == 17 || k == 33) chk("D_rdata", 0, 16'(bus0.rdata), 16'h77);
            @(posedge clk); #1;
        end

        // Reset during phase 4 of a write
        we = 1; addr = 16'h4321; wdata = 8'hE1; req = 1;
        @(posedge clk); #1 req = 0;
        for (int k = 1; k <= 20; k++) begin
            rst = (k == 9);
            @(negedge clk);
            if (k == 9) chk("E_nmwr_pre", 0, 16'(bus0.nmwr), 16'd0);
            if (k == 10) begin
                chk("E_nmwr",  0, 16'(bus0.nmwr),  16'd1);
                chk("E_oe",    0, 16'(bus0.db_oe), 16'd0);
                chk("E_ready", 0, 16'(bus0.ready), 16'd1);
            end
            chk("E_done", 0, 16'(bus0.done), 16'd0);
            @(posedge clk); #1;
        end
        rst = 0;

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
